dac_serial_tx: RTL and testbench
================================

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 The module SHALL have parameter HALF_DIV, default 4: clk_nexys cycles per SCLK half-period; legal range 2..255.
REQ-002 The module SHALL have parameter QUIET_HALVES, default 2: number of SCLK half-periods SYNC stays high between frames; legal range 1..255.
REQ-003 The module SHALL have input clk_nexys, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The module SHALL have input reset, 1 bit: asynchronous, active-low.
REQ-005 The module SHALL have input in_valid, 1 bit: a sample is offered.
REQ-006 The module SHALL have output in_ready, 1 bit: the input buffer is empty, so a sample can be accepted.
REQ-007 The module SHALL have input d_in, 12 bits: DAC code, unsigned.
REQ-008 The module SHALL have input pd, 2 bits: DAC power-down mode bits, captured together with d_in.
REQ-009 The module SHALL have output SCLK, 1 bit: serial clock to the DAC; idles high.
REQ-010 The module SHALL have output SYNC, 1 bit: active-low frame strobe to the DAC.
REQ-011 The module SHALL have output SDATA, 1 bit: serial data, MSB first.
REQ-012 The module SHALL have output busy, 1 bit: high whenever the frame engine is not in IDLE.
REQ-013 The module SHALL have output listo, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-014 Transfer SHALL occur when in_valid && in_ready is high on an edge; {pd,d_in} is then written to a one-entry buffer.
REQ-015 in_ready SHALL equal NOT buffer_full, driven directly from a register with no combinational path from in_valid.
REQ-016 The frame word SHALL be {2'b00, pd, d_in}, 16 bits, sent bit 15 first.
REQ-017 The FSM SHALL have states IDLE, SHIFT, QUIET.
- IDLE -> SHIFT on the first edge where the buffer is full.
- On that edge: the shift register loads from the buffer, the buffer empties, SYNC goes low, and SDATA takes bit 15.
REQ-018 In SHIFT, a divider SHALL count HALF_DIV cycles per half-period.
- SCLK falls HALF_DIV cycles after SYNC falls.
- SCLK then toggles every HALF_DIV cycles.
- SDATA changes only on SCLK rising transitions, so the DAC samples on the falling edge with data stable for HALF_DIV cycles on both sides.
REQ-019 After the 16th SCLK falling edge, HALF_DIV cycles later, the following SHALL happen on the same edge:
- SCLK rises.
- SYNC rises.
- SDATA goes to 0.
- listo pulses high for one cycle.
- The FSM enters QUIET.
SYNC SHALL therefore be low for exactly 32*HALF_DIV cycles.
REQ-020 QUIET SHALL last QUIET_HALVES*HALF_DIV cycles with SYNC and SCLK high, then go to IDLE.
- If the buffer is full on that exit edge, the FSM goes directly to SHIFT and loads, with no IDLE cycle.
REQ-021 Latency from the accepting edge k (engine in IDLE, buffer empty):
- SYNC low and bit 15 on SDATA after edge k+1.
- in_ready low after edge k, high again after edge k+1.
REQ-022 The buffer SHALL accept a new sample at any time while the engine is in SHIFT or QUIET.
- A full buffer holds in_ready low until the next load.
- A buffered sample is never overwritten or dropped.
REQ-023 The shift register and frame contents SHALL NOT be affected by d_in, pd or in_valid changes after capture.
REQ-024 SCLK SHALL never toggle while SYNC is high, and no partial frame SHALL ever be emitted except when truncated by reset.

Reset
REQ-025 While reset is low, the following SHALL hold asynchronously:
- SCLK=1, SYNC=1, SDATA=0.
- busy=0, listo=0, in_ready=1.
- Buffer empty, FSM in IDLE, divider and bit counter cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (SYNC high), discard both the shift and buffer contents, and produce no listo pulse.
REQ-027 After reset release, the first accepted sample SHALL follow the REQ-021 timing.

Verification
REQ-028 Reset check: hold reset low 5 cycles -> SCLK=1, SYNC=1, SDATA=0, in_ready=1, busy=0, listo=0.
REQ-029 Single frame, HALF_DIV=4: d_in=12'hA5C, pd=2'b00 -> bits sampled on 16 SCLK falls equal 0000_1010_0101_1100; SYNC low 128 cycles; one listo pulse coincident with SYNC rise.
REQ-030 pd=2'b11, d_in=12'hFFF -> sampled word 0011_1111_1111_1111; SDATA stable for 4 cycles before and after every SCLK fall.
REQ-031 Back-to-back: offer a second sample 20 cycles into frame 1 -> accepted immediately; SYNC high exactly 8 cycles between frames; frame 2 data correct.
REQ-032 Buffer full: hold in_valid high with three samples during frame 1 -> third held with in_ready low until frame 2 loads; all three frames emitted in order with none lost.
REQ-033 Reset mid-frame after the 7th SCLK fall -> SYNC, SCLK high and SDATA 0 at once; no listo; after release, a new sample is emitted as a complete 16-bit frame.

Source files
------------

// File: rtl/dac_serial_tx.sv
// dac_serial_tx -- serial frame transmitter for a 12-bit DAC with a
// SYNC/SCLK/SDATA interface.
//
// A one-entry input buffer takes {pd, d_in} on a valid/ready handshake. The
// frame engine (IDLE -> SHIFT -> QUIET) loads the buffer into a 16-bit shift
// register, sends {2'b00, pd, d_in} MSB first, and then holds SYNC high for a
// quiet gap before the next frame. SDATA changes only when SCLK rises, so the
// DAC samples on SCLK falling edges with HALF_DIV cycles of setup and hold.
//
// Parameters
//   HALF_DIV     : clk_nexys cycles per SCLK half-period (2..255)
//   QUIET_HALVES : SCLK half-periods of SYNC high between frames (1..255)
// Ports
//   clk_nexys : system clock, rising edge
//   reset     : asynchronous, active-low
//   in_valid  : sample offered
//   in_ready  : input buffer empty (registered)
//   d_in      : 12-bit unsigned DAC code
//   pd        : 2-bit power-down mode, captured with d_in
//   SCLK      : serial clock, idles high
//   SYNC      : active-low frame strobe
//   SDATA     : serial data, MSB first
//   busy      : frame engine not in IDLE
//   listo     : one-cycle pulse as a frame completes
module dac_serial_tx #(
  parameter int HALF_DIV     = 4,
  parameter int QUIET_HALVES = 2
) (
  input  logic        clk_nexys,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] d_in,
  input  logic [1:0]  pd,
  output logic        SCLK,
  output logic        SYNC,
  output logic        SDATA,
  output logic        busy,
  output logic        listo
);

  localparam int QUIET_CYC = QUIET_HALVES * HALF_DIV;
  localparam int DW        = $clog2(HALF_DIV);
  localparam int QW        = $clog2(QUIET_CYC);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t         state, state_n;
  logic [13:0]    buf_q;
  logic [15:0]    shreg;
  logic [DW-1:0]  div;
  logic [4:0]     half;   // SCLK transitions so far; even = fall, odd = rise
  logic [QW-1:0]  qcnt;
  logic           load, tick, fin;
  logic           buf_full;

  // in_ready is the register itself; the buffer is full when it is low.
  assign buf_full = ~in_ready;
  assign busy     = (state != IDLE);
  assign SDATA    = shreg[15];

  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    tick    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (buf_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (div == DIV_LAST) begin
          tick = 1'b1;
          // 32nd transition is the rise after the 16th fall: frame ends.
          if (half == 5'd31) begin
            fin     = 1'b1;
            state_n = QUIET;
          end
        end
      end
      QUIET: begin
        if (qcnt == Q_LAST) begin
          // Chain straight into the next frame when a sample is waiting.
          if (buf_full) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_nexys or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b1;
      buf_q    <= '0;
      shreg    <= '0;
      SCLK     <= 1'b1;
      SYNC     <= 1'b1;
      div      <= '0;
      half     <= '0;
      qcnt     <= '0;
      listo    <= 1'b0;
    end else begin
      listo <= fin;

      // Load only happens with the buffer full (in_ready low), so an
      // accept and a load never land on the same edge.
      if (load) begin
        in_ready <= 1'b1;
      end else if (in_valid && in_ready) begin
        in_ready <= 1'b0;
        buf_q    <= {pd, d_in};
      end

      if (load) begin
        shreg <= {2'b00, buf_q};
        SYNC  <= 1'b0;
        SCLK  <= 1'b1;
        div   <= '0;
        half  <= '0;
      end else if (state == SHIFT) begin
        if (tick) begin
          div  <= '0;
          half <= half + 5'd1;
          if (!half[0]) begin
            SCLK <= 1'b0;
          end else if (fin) begin
            SCLK  <= 1'b1;
            SYNC  <= 1'b1;
            shreg <= '0;
            qcnt  <= '0;
          end else begin
            SCLK  <= 1'b1;
            shreg <= {shreg[14:0], 1'b0};
          end
        end else begin
          div <= div + DW'(1);
        end
      end else if (state == QUIET) begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx (HALF_DIV=4, QUIET_HALVES=2).
// A negedge monitor rebuilds each frame from SDATA at SCLK falls and records
// SYNC low length, the SYNC-high gap before each frame, listo alignment and
// SDATA setup/hold around every fall.
module tb_dac_serial_tx;

  logic        clk_nexys = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] d_in = '0;
  logic [1:0]  pd = '0;
  logic        SCLK, SYNC, SDATA, busy, listo;

  dac_serial_tx #(.HALF_DIV(4), .QUIET_HALVES(2)) dut (
    .clk_nexys(clk_nexys), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready), .d_in(d_in), .pd(pd), .SCLK(SCLK), .SYNC(SYNC),
    .SDATA(SDATA), .busy(busy), .listo(listo)
  );

  always #5 clk_nexys = ~clk_nexys;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] word_q[$];
  int          nfall_q[$];
  int          len_q[$];
  int          gap_q[$];
  logic [15:0] cur = '0;
  int cyc = 0, nfall = 0, low_cnt = 0, high_cnt = 0;
  int last_chg = 0, last_fall = 0;
  int listo_cnt = 0, listo_bad = 0, sclk_bad = 0, stab_bad = 0;
  logic prev_sync = 1'b1, prev_sclk = 1'b1, prev_sdata = 1'b0;

  always @(negedge clk_nexys) begin
    cyc++;
    if (!reset) begin
      nfall = 0; cur = '0;
      prev_sync = 1'b1; prev_sclk = 1'b1; prev_sdata = 1'b0;
    end else begin
      if (listo) begin
        listo_cnt++;
        if (!(SYNC && !prev_sync)) listo_bad++;
      end
      if (SYNC && prev_sync && (SCLK != prev_sclk)) sclk_bad++;
      if (!SYNC && prev_sync) begin
        nfall = 0; cur = '0; low_cnt = 1;
        last_chg = cyc; last_fall = cyc - 100;
        gap_q.push_back(high_cnt);
      end else if (!SYNC) begin
        low_cnt++;
        if (prev_sclk && !SCLK) begin
          cur = {cur[14:0], SDATA};
          nfall++;
          if (cyc - last_chg < 4) stab_bad++;
          last_fall = cyc;
        end
        if (SDATA != prev_sdata) begin
          if (cyc - last_fall < 4) stab_bad++;
          last_chg = cyc;
        end
      end else if (!prev_sync) begin
        word_q.push_back(cur);
        nfall_q.push_back(nfall);
        len_q.push_back(low_cnt);
        high_cnt = 1;
      end else begin
        high_cnt++;
      end
      prev_sync = SYNC; prev_sclk = SCLK; prev_sdata = SDATA;
    end
  end

  // ---------------- helpers ----------------
  // Offers a sample and leaves in_valid high; returns after the accepting
  // edge (+1). waited = negedges seen with in_ready low before acceptance.
  task automatic send(input logic [1:0] p, input logic [11:0] d, output int waited);
    waited = 0;
    @(negedge clk_nexys);
    pd = p; d_in = d; in_valid = 1'b1;
    while (!in_ready && waited < 2000) begin
      @(negedge clk_nexys);
      waited++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk_nexys); #1;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (word_q.size() < n && t < 3000) begin
      @(posedge clk_nexys);
      t++;
    end
    chk("frame_timeout", 32'(word_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || !in_ready) && t < 3000) begin
      @(posedge clk_nexys); #1;
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic clear_mon();
    word_q.delete(); nfall_q.delete(); len_q.delete(); gap_q.delete();
    listo_cnt = 0; listo_bad = 0; stab_bad = 0;
  endtask

  task automatic chk_frame(input string tag, input int i, input logic [15:0] exp);
    chk({tag, "_word"}, 32'(word_q[i]), 32'(exp));
    chk({tag, "_falls"}, 32'(nfall_q[i]), 32'd16);
    chk({tag, "_synclow"}, 32'(len_q[i]), 32'd128);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, wb, wc, lc, t;

    // Reset state
    repeat (5) @(negedge clk_nexys);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_sync", 32'(SYNC), 32'd1);
    chk("rst_sdata", 32'(SDATA), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_nexys);

    // Single frame 0xA5C with latency checks
    clear_mon();
    send(2'b00, 12'hA5C, w);
    in_valid = 1'b0;
    chk("lat_ready_k", 32'(in_ready), 32'd0);
    chk("lat_sync_k", 32'(SYNC), 32'd1);
    @(posedge clk_nexys); #1;
    chk("lat_sync_k1", 32'(SYNC), 32'd0);
    chk("lat_sdata_k1", 32'(SDATA), 32'd0);
    chk("lat_ready_k1", 32'(in_ready), 32'd1);
    chk("lat_busy_k1", 32'(busy), 32'd1);
    wait_frames(1);
    @(posedge clk_nexys);
    chk_frame("f_a5c", 0, 16'h0A5C);
    chk("f_a5c_listo", 32'(listo_cnt), 32'd1);
    chk("f_a5c_listo_align", 32'(listo_bad), 32'd0);
    chk("f_a5c_stab", 32'(stab_bad), 32'd0);

    // All-ones payload with power-down bits, setup/hold check
    wait_idle();
    clear_mon();
    send(2'b11, 12'hFFF, w);
    in_valid = 1'b0;
    wait_frames(1);
    @(posedge clk_nexys);
    chk_frame("f_fff", 0, 16'h3FFF);
    chk("f_fff_stab", 32'(stab_bad), 32'd0);

    // Back-to-back: second sample offered 20 cycles into frame 1
    wait_idle();
    clear_mon();
    send(2'b01, 12'h123, w);
    in_valid = 1'b0;
    repeat (20) @(posedge clk_nexys);
    send(2'b10, 12'hBEE, w);
    in_valid = 1'b0;
    chk("b2b_accept_wait", 32'(w), 32'd0);
    wait_frames(2);
    @(posedge clk_nexys);
    chk_frame("b2b_f1", 0, 16'h1123);
    chk_frame("b2b_f2", 1, 16'h2BEE);
    chk("b2b_gap", 32'(gap_q[gap_q.size()-1]), 32'd8);
    chk("b2b_listo", 32'(listo_cnt), 32'd2);

    // Buffer full: three samples with in_valid held high
    wait_idle();
    clear_mon();
    send(2'b00, 12'h111, w);
    send(2'b01, 12'h222, wb);
    send(2'b10, 12'h333, wc);
    in_valid = 1'b0;
    chk("full_b_wait", 32'(wb), 32'd1);
    chk("full_c_wait", 32'(wc), 32'd135);
    wait_frames(3);
    @(posedge clk_nexys);
    chk_frame("full_f1", 0, 16'h0111);
    chk_frame("full_f2", 1, 16'h1222);
    chk_frame("full_f3", 2, 16'h2333);
    chk("full_nframes", 32'(word_q.size()), 32'd3);
    chk("full_listo", 32'(listo_cnt), 32'd3);

    // Reset mid-frame after the 7th SCLK fall, with a sample buffered
    wait_idle();
    clear_mon();
    send(2'b00, 12'h7E1, w);
    send(2'b11, 12'h0AB, w);
    in_valid = 1'b0;
    t = 0;
    while (nfall < 7 && t < 1000) begin
      @(posedge clk_nexys);
      t++;
    end
    chk("mid_reach7", 32'(nfall), 32'd7);
    lc = listo_cnt;
    @(negedge clk_nexys); #2;
    reset = 1'b0;
    #1;
    chk("mid_sync", 32'(SYNC), 32'd1);
    chk("mid_sclk", 32'(SCLK), 32'd1);
    chk("mid_sdata", 32'(SDATA), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk_nexys);
    reset = 1'b1;
    repeat (300) @(posedge clk_nexys);
    chk("mid_no_listo", 32'(listo_cnt), 32'(lc));
    chk("mid_no_frame", 32'(word_q.size()), 32'd0);
    chk("mid_buf_dropped", 32'(busy), 32'd0);
    send(2'b01, 12'h5A3, w);
    in_valid = 1'b0;
    @(posedge clk_nexys); #1;
    chk("post_sync", 32'(SYNC), 32'd0);
    wait_frames(1);
    @(posedge clk_nexys);
    chk_frame("post_f", 0, 16'h15A3);
    chk("sclk_idle_toggle", 32'(sclk_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
